// File: rtl/core_branch_ctrl.sv
// core_branch_ctrl: EX-stage control-flow redirect sequencer (IDLE -> REDIRECT -> FLUSH).
// Optional feature macro BRANCH_STATS_EN enables the STAT_* counters (tied to 0 otherwise).
module core_branch_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_iscond,
  input  logic             ex_isjal,
  input  logic             ex_isjalr,
  input  logic             isbranch,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      reg_rdata1,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             stall_ex,
  output logic             misalign_exc,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_nottaken,
  output logic [CNT_W-1:0] stat_jump,
  output logic [CNT_W-1:0] stat_misalign
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = (FLUSH_CYCLES > 0) ? CW'(FLUSH_CYCLES - 1) : {CW{1'b0}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_nxt_s;

  logic [31:0]    target_s;
  logic           idle_s;
  logic           event_s;
  logic           misalign_s;
  logic           redirect_s;
  logic           nottaken_s;

  logic           valid_nxt_s;
  logic [31:0]    pc_nxt_s;
  logic           flush_if_nxt_s;
  logic           flush_id_nxt_s;
  logic           stall_nxt_s;

  logic           redirect_valid_r;
  logic [31:0]    redirect_pc_r;
  logic           flush_if_r;
  logic           flush_id_r;
  logic           stall_ex_r;
  logic           misalign_exc_r;

  // Target computation and event classification; EX inputs only matter in IDLE
  always_comb begin
    target_s = ex_pc + ex_imm;
    if (ex_isjalr) begin
      target_s = (reg_rdata1 + ex_imm) & ~32'h0000_0001;
    end else begin
      target_s = ex_pc + ex_imm;
    end
    idle_s     = (state_r == IDLE);
    event_s    = idle_s & ex_valid & (ex_isjal | ex_isjalr | (ex_iscond & isbranch));
    misalign_s = event_s & target_s[1];
    redirect_s = event_s & ~target_s[1];
    nottaken_s = idle_s & ex_valid & ex_iscond & ~isbranch;
  end

  // State and flush-counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (redirect_s) begin
          state_nxt_s = REDIRECT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          if (FLUSH_CYCLES > 0) begin
            state_nxt_s = FLUSH;
            cnt_nxt_s   = CNT_INIT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = REDIRECT;
        end
      end
      FLUSH: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r - CW'(1'b1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Next output values, derived from the upcoming state so outputs can be registered
  always_comb begin
    valid_nxt_s    = (state_nxt_s == REDIRECT);
    flush_if_nxt_s = (state_nxt_s == REDIRECT);
    flush_id_nxt_s = (state_nxt_s != IDLE);
    stall_nxt_s    = (state_nxt_s != IDLE);
    if (redirect_s) begin
      pc_nxt_s = target_s;
    end else if (state_nxt_s == REDIRECT) begin
      pc_nxt_s = redirect_pc_r;
    end else begin
      pc_nxt_s = 32'h0000_0000;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'h0000_0000;
      flush_if_r       <= 1'b0;
      flush_id_r       <= 1'b0;
      stall_ex_r       <= 1'b0;
      misalign_exc_r   <= 1'b0;
    end else begin
      redirect_valid_r <= valid_nxt_s;
      redirect_pc_r    <= pc_nxt_s;
      flush_if_r       <= flush_if_nxt_s;
      flush_id_r       <= flush_id_nxt_s;
      stall_ex_r       <= stall_nxt_s;
      misalign_exc_r   <= misalign_s;
    end
  end

  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign flush_if       = flush_if_r;
  assign flush_id       = flush_id_r;
  assign stall_ex       = stall_ex_r;
  assign misalign_exc   = misalign_exc_r;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] stat_taken_r;
  logic [CNT_W-1:0] stat_nottaken_r;
  logic [CNT_W-1:0] stat_jump_r;
  logic [CNT_W-1:0] stat_misalign_r;

  // Statistics counters, bumped at the event edge and wrapping silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_taken_r    <= {CNT_W{1'b0}};
      stat_nottaken_r <= {CNT_W{1'b0}};
      stat_jump_r     <= {CNT_W{1'b0}};
      stat_misalign_r <= {CNT_W{1'b0}};
    end else begin
      if (redirect_s & ex_iscond) begin
        stat_taken_r <= stat_taken_r + CNT_W'(1'b1);
      end
      if (nottaken_s) begin
        stat_nottaken_r <= stat_nottaken_r + CNT_W'(1'b1);
      end
      if (redirect_s & (ex_isjal | ex_isjalr)) begin
        stat_jump_r <= stat_jump_r + CNT_W'(1'b1);
      end
      if (misalign_s) begin
        stat_misalign_r <= stat_misalign_r + CNT_W'(1'b1);
      end
    end
  end

  assign stat_taken    = stat_taken_r;
  assign stat_nottaken = stat_nottaken_r;
  assign stat_jump     = stat_jump_r;
  assign stat_misalign = stat_misalign_r;
`else
  assign stat_taken    = {CNT_W{1'b0}};
  assign stat_nottaken = {CNT_W{1'b0}};
  assign stat_jump     = {CNT_W{1'b0}};
  assign stat_misalign = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_core_branch_ctrl.sv
// tb_core_branch_ctrl: directed and randomized checks of core_branch_ctrl against a
// transaction-level model (target arithmetic, handshake hold, flush length, statistics).
module tb_core_branch_ctrl;

  localparam int FC = 2;
  localparam int CW = 32;
`ifdef BRANCH_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid, ex_iscond, ex_isjal, ex_isjalr, isbranch;
  logic [31:0]   ex_pc, ex_imm, reg_rdata1;
  logic          redirect_ready;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          flush_if, flush_id, stall_ex, misalign_exc;
  logic [CW-1:0] stat_taken, stat_nottaken, stat_jump, stat_misalign;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] m_taken, m_nottaken, m_jump, m_mis;

  core_branch_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_iscond(ex_iscond), .ex_isjal(ex_isjal), .ex_isjalr(ex_isjalr),
    .isbranch(isbranch), .ex_pc(ex_pc), .ex_imm(ex_imm), .reg_rdata1(reg_rdata1),
    .redirect_ready(redirect_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if(flush_if), .flush_id(flush_id), .stall_ex(stall_ex), .misalign_exc(misalign_exc),
    .stat_taken(stat_taken), .stat_nottaken(stat_nottaken), .stat_jump(stat_jump),
    .stat_misalign(stat_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_ex(input logic v, input logic c, input logic j, input logic jr,
                          input logic b, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1);
    ex_valid = v; ex_iscond = c; ex_isjal = j; ex_isjalr = jr; isbranch = b;
    ex_pc = pc; ex_imm = imm; reg_rdata1 = rs1;
  endtask

  task automatic drive_idle();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  // Random EX traffic presented while the controller is busy; it must be ignored.
  task automatic drive_junk();
    int s;
    s = int'($urandom_range(0, 3));
    drive_ex(1'($urandom_range(0, 1)), s == 1, s == 2, s == 3, 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_ready = 1'b0; drive_idle();
    m_taken = 32'h0; m_nottaken = 32'h0; m_jump = 32'h0; m_mis = 32'h0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b00000 || redirect_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: flags=%b pc=%h, expected flags=00000 pc=00000000",
               {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc}, redirect_pc);
    end
    tests_run++;
    if ({stat_taken, stat_nottaken, stat_jump, stat_misalign} !== 128'h0) begin
      tests_failed++;
      $display("FAIL reset_stats: got %h %h %h %h, expected all 0", stat_taken, stat_nottaken, stat_jump, stat_misalign);
    end
    rst = 1'b0;
  endtask

  task automatic test_beq_taken();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h20, 32'h0);
    redirect_ready = 1'b0;
    @(negedge clk);
    m_taken++;
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b11110 || redirect_pc !== 32'h120) begin
        tests_failed++;
        $display("FAIL beq_hold[%0d]: flags=%b pc=%h, expected flags=11110 pc=00000120", i,
                 {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc}, redirect_pc);
      end
      if (i == 3) redirect_ready = 1'b1;
      @(negedge clk);
    end
    redirect_ready = 1'b0;
    for (int f = 0; f < FC; f++) begin
      tests_run++;
      if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b00110) begin
        tests_failed++;
        $display("FAIL beq_flush[%0d]: flags=%b, expected 00110", f,
                 {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc});
      end
      @(negedge clk);
    end
    tests_run++;
    if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b00000 || redirect_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL beq_idle: flags=%b pc=%h, expected flags=00000 pc=00000000",
               {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc}, redirect_pc);
    end
  endtask

  task automatic test_jalr_misalign();
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h1003);
    @(negedge clk);
    m_mis++;
    drive_idle();
    tests_run++;
    if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b00001) begin
      tests_failed++;
      $display("FAIL jalr_misalign: flags=%b, expected 00001", {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc});
    end
    @(negedge clk);
    tests_run++;
    if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b00000 || redirect_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL misalign_pulse_end: flags=%b pc=%h, expected flags=00000 pc=00000000",
               {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc}, redirect_pc);
    end
  endtask

  task automatic test_jal_wrap();
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0);
    @(negedge clk);
    m_jump++;
    drive_idle();
    tests_run++;
    if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b11110 || redirect_pc !== 32'h10) begin
      tests_failed++;
      $display("FAIL jal_wrap: flags=%b pc=%h, expected flags=11110 pc=00000010",
               {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc}, redirect_pc);
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    repeat (FC) @(negedge clk);
    tests_run++;
    if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL jal_wrap_idle: flags=%b, expected 00000", {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc});
    end
  endtask

  task automatic test_not_taken();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h40, 32'h0);
    @(negedge clk);
    m_nottaken++;
    drive_idle();
    tests_run++;
    if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b00000 || redirect_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL bne_not_taken: flags=%b pc=%h, expected flags=00000 pc=00000000",
               {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc}, redirect_pc);
    end
    tests_run++;
    if ({stat_taken, stat_nottaken, stat_jump, stat_misalign} !==
        (STATS_ON ? {m_taken, m_nottaken, m_jump, m_mis} : 128'h0)) begin
      tests_failed++;
      $display("FAIL stats_directed: got %0d %0d %0d %0d, expected %0d %0d %0d %0d (stats %0b)",
               stat_taken, stat_nottaken, stat_jump, stat_misalign, m_taken, m_nottaken, m_jump, m_mis, STATS_ON);
    end
  endtask

  task automatic test_back_to_back();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h400, 32'h40, 32'h0);
    redirect_ready = 1'b1;
    @(negedge clk);
    m_taken++;
    drive_idle();
    tests_run++;
    if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b11110 || redirect_pc !== 32'h440) begin
      tests_failed++;
      $display("FAIL b2b_first: flags=%b pc=%h, expected flags=11110 pc=00000440",
               {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc}, redirect_pc);
    end
    @(negedge clk);
    for (int f = 0; f < FC; f++) begin
      tests_run++;
      if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b00110) begin
        tests_failed++;
        $display("FAIL b2b_flush[%0d]: flags=%b, expected 00110", f, {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc});
      end
      if (f == FC - 1) drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h800, 32'h10, 32'h0);
      @(negedge clk);
    end
    // The jump was presented on the edge leaving FLUSH, so only its second cycle counts.
    tests_run++;
    if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b00000 || redirect_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL b2b_ignored: flags=%b pc=%h, expected flags=00000 pc=00000000",
               {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc}, redirect_pc);
    end
    @(negedge clk);
    m_jump++;
    drive_idle();
    tests_run++;
    if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b11110 || redirect_pc !== 32'h810) begin
      tests_failed++;
      $display("FAIL b2b_second: flags=%b pc=%h, expected flags=11110 pc=00000810",
               {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc}, redirect_pc);
    end
    @(negedge clk);
    redirect_ready = 1'b0;
    repeat (FC) @(negedge clk);
    tests_run++;
    if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL b2b_idle: flags=%b, expected 00000", {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc});
    end
  endtask

  task automatic test_reset_mid();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h100, 32'h0);
    redirect_ready = 1'b0;
    @(negedge clk);
    drive_idle();
    #2 rst = 1'b1;
    #1;
    m_taken = 32'h0; m_nottaken = 32'h0; m_jump = 32'h0; m_mis = 32'h0;
    tests_run++;
    if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b00000 || redirect_pc !== 32'h0 ||
        {stat_taken, stat_nottaken, stat_jump, stat_misalign} !== 128'h0) begin
      tests_failed++;
      $display("FAIL async_reset: flags=%b pc=%h taken=%0d, expected flags=00000 pc=00000000 taken=0",
               {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc}, redirect_pc, stat_taken);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2000, 32'h8, 32'h0);
    @(negedge clk);
    m_taken++;
    drive_idle();
    tests_run++;
    if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b11110 || redirect_pc !== 32'h2008) begin
      tests_failed++;
      $display("FAIL post_reset_redirect: flags=%b pc=%h, expected flags=11110 pc=00002008",
               {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc}, redirect_pc);
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    repeat (FC) @(negedge clk);
  endtask

  task automatic test_random();
    logic        v, c, j, jr, b, taken;
    logic [31:0] pc, imm, rs1, tgt;
    int          kind, w;
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 4));
      pc   = $urandom & 32'hFFFF_FFFC;
      imm  = $urandom;
      rs1  = $urandom;
      if ($urandom_range(0, 1) == 0) imm[1:0] = 2'b00;
      v = 1'b1; c = 1'b0; j = 1'b0; jr = 1'b0; b = 1'($urandom_range(0, 1));
      case (kind)
        0: begin c = 1'b1; b = 1'b1; end
        1: begin c = 1'b1; b = 1'b0; end
        2: j = 1'b1;
        3: jr = 1'b1;
        default: begin v = 1'b0; c = 1'b1; end
      endcase
      drive_ex(v, c, j, jr, b, pc, imm, rs1);
      redirect_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      taken = v && (j || jr || (c && b));
      tgt   = jr ? ((rs1 + imm) & ~32'h1) : (pc + imm);
      if (v && c && !b) m_nottaken++;
      if (!taken) begin
        drive_idle();
        tests_run++;
        if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b00000 || redirect_pc !== 32'h0) begin
          tests_failed++;
          $display("FAIL rnd_no_action[%0d]: flags=%b pc=%h, expected 00000/0", n,
                   {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc}, redirect_pc);
        end
      end else if (tgt[1]) begin
        m_mis++;
        drive_idle();
        tests_run++;
        if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b00001) begin
          tests_failed++;
          $display("FAIL rnd_misalign[%0d]: flags=%b, expected 00001", n, {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc});
        end
        @(negedge clk);
        tests_run++;
        if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b00000) begin
          tests_failed++;
          $display("FAIL rnd_misalign_end[%0d]: flags=%b, expected 00000", n, {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc});
        end
      end else begin
        if (c) m_taken++;
        else   m_jump++;
        w = int'($urandom_range(0, 3));
        for (int i = 0; i <= w; i++) begin
          tests_run++;
          if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b11110 || redirect_pc !== tgt) begin
            tests_failed++;
            $display("FAIL rnd_redirect[%0d.%0d]: flags=%b pc=%h, expected flags=11110 pc=%h", n, i,
                     {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc}, redirect_pc, tgt);
          end
          drive_junk();
          redirect_ready = (i == w);
          @(negedge clk);
        end
        for (int f = 0; f < FC; f++) begin
          tests_run++;
          if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b00110) begin
            tests_failed++;
            $display("FAIL rnd_flush[%0d.%0d]: flags=%b, expected 00110", n, f, {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc});
          end
          if (f == FC - 1) drive_idle();
          else drive_junk();
          redirect_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        drive_idle();
        redirect_ready = 1'b0;
        tests_run++;
        if ({redirect_valid, flush_if, flush_id, stall_ex, misalign_exc} !== 5'b00000 || redirect_pc !== 32'h0) begin
          tests_failed++;
          $display("FAIL rnd_idle[%0d]: flags=%b pc=%h, expected 00000/0", n,
                   {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc}, redirect_pc);
        end
      end
      tests_run++;
      if ({stat_taken, stat_nottaken, stat_jump, stat_misalign} !==
          (STATS_ON ? {m_taken, m_nottaken, m_jump, m_mis} : 128'h0)) begin
        tests_failed++;
        $display("FAIL rnd_stats[%0d]: got %0d %0d %0d %0d, expected %0d %0d %0d %0d (stats %0b)", n,
                 stat_taken, stat_nottaken, stat_jump, stat_misalign, m_taken, m_nottaken, m_jump, m_mis, STATS_ON);
      end
    end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_jalr_misalign();
    test_jal_wrap();
    test_not_taken();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
